// File: rtl/bitwise_op_stage.sv
// Registered AND/OR/NOT/BUF stage with a 2-entry valid/ready output queue.
// Optional per-entry zero/logic flags are enabled by BITWISE_OP_FLAGS_EN.
module bitwise_op_stage #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_op,
`ifdef BITWISE_OP_FLAGS_EN
  output logic             out_zero,
  output logic             out_logic,
`endif
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [1:0]       op;
`ifdef BITWISE_OP_FLAGS_EN
    logic             zero;
    logic             lgc;
`endif
  } entry_t;

  state_e     state_q, state_d;
  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  entry_t     new_e;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       push, pop;
  logic       a_nz, b_nz;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;
  assign a_nz = |in_a;
  assign b_nz = |in_b;

  always_comb begin
    new_e    = '0;
    new_e.op = in_op;
    unique case (in_op)
      2'b00: new_e.data = in_a & in_b;
      2'b01: new_e.data = in_a | in_b;
      2'b10: new_e.data = ~in_a;
      2'b11: new_e.data = in_a;
      default: new_e.data = '0;
    endcase
`ifdef BITWISE_OP_FLAGS_EN
    new_e.zero = ~|new_e.data;
    unique case (in_op)
      2'b00: new_e.lgc = a_nz && b_nz;
      2'b01: new_e.lgc = a_nz || b_nz;
      2'b10: new_e.lgc = !a_nz;
      2'b11: new_e.lgc = a_nz;
      default: new_e.lgc = 1'b0;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (!push && pop) state_d = EMPTY;
      end
      FULL: if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = (state_q != FULL);
    out_valid = (state_q != EMPTY);
  end

  // Head is always the oldest entry; tail only holds the second one.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    unique case (state_q)
      EMPTY: if (push) head_d = new_e;
      ONE: begin
        if (push && pop) head_d = new_e;
        else if (push)   tail_d = new_e;
      end
      FULL: if (pop) head_d = tail_q;
      default: ;
    endcase
  end

  assign cnt_d = cnt_q + CNT_W'(push);

  assign out_data  = head_q.data;
  assign out_op    = head_q.op;
  assign op_count  = cnt_q;
`ifdef BITWISE_OP_FLAGS_EN
  assign out_zero  = head_q.zero;
  assign out_logic = head_q.lgc;
`endif

endmodule

// File: tb/tb_bitwise_op_stage.sv
// Directed scoreboard bench for bitwise_op_stage.
// Flag checks are compiled in with BITWISE_OP_FLAGS_EN.
module tb_bitwise_op_stage;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [1:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [1:0] out_op;
  logic [7:0] op_count;
`ifdef BITWISE_OP_FLAGS_EN
  logic       out_zero;
  logic       out_logic;
`endif

  typedef struct {
    logic [3:0] d;
    logic [1:0] op;
    logic       z;
    logic       l;
  } exp_t;

  exp_t       sb[$];
  exp_t       cur;
  logic [7:0] exp_cnt;
  bit         en;
  int         nchk;
  int         nfail;

  bitwise_op_stage #(
    .WIDTH(4),
    .CNT_W(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_op    (in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_op   (out_op),
`ifdef BITWISE_OP_FLAGS_EN
    .out_zero (out_zero),
    .out_logic(out_logic),
`endif
    .op_count (op_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t model(
    logic [3:0] a, logic [3:0] b, logic [1:0] op
  );
    exp_t r;
    r.op = op;
    case (op)
      2'b00: begin r.d = a & b; r.l = (a != 0) && (b != 0); end
      2'b01: begin r.d = a | b; r.l = (a != 0) || (b != 0); end
      2'b10: begin r.d = ~a;    r.l = (a == 0); end
      default: begin r.d = a;   r.l = (a != 0); end
    endcase
    r.z = (r.d == 4'd0);
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: predict on accept, compare on pop.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      exp_cnt = '0;
      en = 1'b1;
    end else if (en) begin
      chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(sb.size() != 2));
      chk("op_count", 32'(op_count), 32'(exp_cnt));
      if (out_valid && out_ready && sb.size() > 0) begin
        cur = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(cur.d));
        chk("out_op", 32'(out_op), 32'(cur.op));
`ifdef BITWISE_OP_FLAGS_EN
        chk("out_zero", 32'(out_zero), 32'(cur.z));
        chk("out_logic", 32'(out_logic), 32'(cur.l));
`endif
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(in_a, in_b, in_op));
        exp_cnt = exp_cnt + 8'd1;
      end
    end
  end

  task automatic scramble();
    in_a  = 4'($urandom);
    in_b  = 4'($urandom);
    in_op = 2'($urandom);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      scramble();
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_accept();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
      if (ok) break;
    end
    in_valid = 1'b0;
    scramble();
    chk("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send(logic [3:0] a, logic [3:0] b, logic [1:0] op);
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_valid = 1'b1;
    wait_accept();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    nchk = 0; nfail = 0; en = 1'b0;
    exp_cnt = '0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_op", 32'(out_op), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    rst_n = 1'b1;

    out_ready = 1'b1;
    send(4'b1100, 4'b1010, 2'b00);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data), 32'b1000);
    chk("t1_op", 32'(out_op), 32'd0);
    chk("t1_count", 32'(op_count), 32'd1);
    idle(2);

    do_reset();
    out_ready = 1'b1;
    send(4'b0110, 4'b0011, 2'b00);
    send(4'b0110, 4'b0011, 2'b01);
    send(4'b0110, 4'b0011, 2'b10);
    send(4'b0110, 4'b0011, 2'b11);
    chk("ops_count", 32'(op_count), 32'd4);
    chk("ops_last", 32'(out_data), 32'b0110);
    idle(3);

    do_reset();
    out_ready = 1'b0;
    send(4'b0011, 4'b0101, 2'b01);
    send(4'b1111, 4'b0000, 2'b10);
    chk("bp_full", 32'(in_ready), 32'd0);
    in_a = 4'b1010; in_b = 4'b0111; in_op = 2'b11;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_stall", 32'(in_ready), 32'd0);
      chk("bp_head", 32'(out_data), 32'b0111);
    end
    out_ready = 1'b1;
    wait_accept();
    idle(4);
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_count", 32'(op_count), 32'd3);

    do_reset();
    out_ready = 1'b1;
    send(4'b1001, 4'b0011, 2'b00);
    send(4'b1001, 4'b0100, 2'b01);
    send(4'b1101, 4'b0111, 2'b00);
    chk("pp_valid", 32'(out_valid), 32'd1);
    chk("pp_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("hold_data", 32'(out_data), 32'b0101);
      chk("hold_op", 32'(out_op), 32'd0);
    end
    out_ready = 1'b1;
    idle(2);

    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++)
      send(4'($urandom), 4'($urandom), 2'($urandom));
    chk("wrap_count", 32'(op_count), 32'd0);
    idle(2);
    out_ready = 1'b0;
    send(4'b0001, 4'b0010, 2'b01);
    send(4'b0100, 4'b1000, 2'b01);
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    do_reset();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", 32'(op_count), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    idle(2);

`ifdef BITWISE_OP_FLAGS_EN
    do_reset();
    out_ready = 1'b0;
    send(4'b0101, 4'b1010, 2'b00);
    chk("flg_data", 32'(out_data), 32'd0);
    chk("flg_zero", 32'(out_zero), 32'd1);
    chk("flg_logic", 32'(out_logic), 32'd1);
    out_ready = 1'b1;
    idle(2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
